frame_config_controller: RTL and testbench

- Sequences the pixel-generation datapath's configuration from the board controls: debounces KEY[1:0], holds a pending mode/freeze, and commits pending values plus SW to the datapath only at a frame boundary (v_sync rising edge), so a frame is never torn.
- Drives status onto LEDR and HEX0..HEX5.
- Sits between the board I/O and the combinational pixel generator, in the vga_clk domain.

---
 rtl/frame_cfg_pkg.sv | 18 +
 rtl/key_debouncer.sv | 34 +++
 rtl/frame_config_controller.sv | 106 ++++++++++
 tb/tb_frame_config_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared mode encodings, seven-segment glyphs and commit FSM type
package frame_cfg_pkg;
  localparam logic [2:0] MODE_PASS   = 3'd0;
  localparam logic [2:0] MODE_GRAY   = 3'd1;
  localparam logic [2:0] MODE_INVERT = 3'd2;
  localparam logic [2:0] MODE_THRESH = 3'd3;
  localparam logic [2:0] MODE_EDGE   = 3'd4;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  // Active-low glyphs, dp off; index 0 is the rightmost entry
  localparam logic [15:0][7:0] SEG_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  typedef enum logic {IDLE, PENDING} state_t;
  function automatic logic [7:0] hex_to_seg(input logic [3:0] d);
    return SEG_GLYPH[d];
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes an async active-low key and emits a pulse on an accepted press
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic vga_clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, hit;
  logic [CW-1:0] cnt;
  assign hit = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Two-flop synchronizer feeding a stability counter; level flips once the change has held long enough
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= hit & ~s2;
      if (s2 == level) cnt <= '0;
      else if (hit) begin
        level <= s2;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/frame_config_controller.sv
// frame_config_controller: debounced key control of mode/freeze, committed to the datapath at frame boundaries
module frame_config_controller
  import frame_cfg_pkg::*;
#(
  parameter int NUM_MODES       = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAME_CNT_W     = 8
) (
  input  logic                   vga_clk,
  input  logic                   rst_n,
  input  logic                   v_sync,
  input  logic [1:0]             KEY,
  input  logic [9:0]             SW,
  output logic [2:0]             mode,
  output logic [9:0]             param,
  output logic                   freeze,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [9:0]             LEDR,
  output logic [7:0]             HEX0,
  output logic [7:0]             HEX1,
  output logic [7:0]             HEX2,
  output logic [7:0]             HEX3,
  output logic [7:0]             HEX4,
  output logic [7:0]             HEX5
);
  logic lvl0, lvl1, prs0, prs1, p0, p1;
  logic v_sync_d, armed, commit, dirty, pending_freeze;
  logic [2:0] pending_mode;
  state_t state, state_nx;
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .vga_clk(vga_clk), .rst_n(rst_n), .key_n(KEY[0]), .level(lvl0), .press(prs0)
  );
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .vga_clk(vga_clk), .rst_n(rst_n), .key_n(KEY[1]), .level(lvl1), .press(prs1)
  );
  // A press pulse always coincides with the debounced level having just dropped
  assign p0 = prs0 & ~lvl0;
  assign p1 = prs1 & ~lvl1;
  // armed blocks a commit when v_sync is already high as reset releases
  assign commit = v_sync & ~v_sync_d & armed;
  // Commit FSM state register
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // A press outranks a same-cycle commit so the new pending value is still flagged
  always_comb state_nx = (p0 | p1) ? PENDING : commit ? IDLE : state;
  // Dirty flag decoded from the FSM state
  always_comb dirty = (state == PENDING);
  // Frame-boundary edge detector
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sync_d <= 1'b0;
      armed    <= 1'b0;
    end else begin
      v_sync_d <= v_sync;
      armed    <= armed | ~v_sync;
    end
  end
  // Pending mode/freeze driven by key presses
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_mode   <= MODE_PASS;
      pending_freeze <= 1'b0;
    end else begin
      if (p0) pending_mode <= (pending_mode == 3'(NUM_MODES - 1)) ? MODE_PASS : pending_mode + 3'd1;
      if (p1) pending_freeze <= ~pending_freeze;
    end
  end
  // Active configuration, updated only on a commit
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= MODE_PASS;
      param       <= '0;
      freeze      <= 1'b0;
      frame_count <= '0;
    end else if (commit) begin
      freeze      <= pending_freeze;
      frame_count <= frame_count + 1'b1;
      if (!pending_freeze) begin
        mode  <= pending_mode;
        param <= SW;
      end
    end
  end
  // Registered status LEDs and seven-segment digits
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      LEDR <= '0;
      HEX0 <= hex_to_seg(4'd0);
      HEX1 <= hex_to_seg(4'd0);
      HEX2 <= hex_to_seg(4'd0);
      HEX3 <= SEG_BLANK;
      HEX4 <= hex_to_seg(4'd0);
      HEX5 <= hex_to_seg(4'd0);
    end else begin
      LEDR <= {frame_count[1:0], pending_mode, dirty, freeze, mode};
      HEX0 <= hex_to_seg(param[3:0]);
      HEX1 <= hex_to_seg(param[7:4]);
      HEX2 <= hex_to_seg({2'b00, param[9:8]});
      HEX3 <= SEG_BLANK;
      HEX4 <= hex_to_seg({1'b0, pending_mode});
      HEX5 <= hex_to_seg({1'b0, mode});
    end
  end
endmodule

// File: tb/tb_frame_config_controller.sv
// tb_frame_config_controller: scoreboard bench with a frame-level reference model
module tb_frame_config_controller;
  localparam int NM = 5;
  logic vga_clk = 0, rst_n = 0, v_sync = 0;
  logic [1:0] KEY = 2'b11;
  logic [9:0] SW = '0;
  logic [2:0] mode;
  logic [9:0] param, LEDR;
  logic freeze;
  logic [7:0] frame_count, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int total = 0, bad = 0;
  typedef struct packed {
    logic [2:0] mode;
    logic [9:0] param;
    logic       fr;
    logic [7:0] fc;
    logic [2:0] pm;
    logic       dirty;
  } exp_t;
  exp_t q[$];
  logic [2:0] m_mode, m_pm;
  logic [9:0] m_param;
  logic m_fr, m_pf, m_dirty;
  logic [7:0] m_fc;

  frame_config_controller #(.NUM_MODES(NM), .DEBOUNCE_CYCLES(4), .FRAME_CNT_W(8)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .v_sync(v_sync), .KEY(KEY), .SW(SW),
    .mode(mode), .param(param), .freeze(freeze), .frame_count(frame_count), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pm = 0; m_param = 0; m_fr = 0; m_pf = 0; m_dirty = 0; m_fc = 0;
  endtask

  task automatic model_press(input logic [1:0] k);
    if (k[0]) m_pm = 3'((int'(m_pm) + 1) % NM);
    if (k[1]) m_pf = ~m_pf;
    m_dirty = 1;
  endtask

  task automatic model_commit(input logic [9:0] sw);
    if (!m_pf) begin
      m_mode = m_pm;
      m_param = sw;
    end
    m_fr = m_pf;
    m_fc = m_fc + 8'd1;
    m_dirty = 0;
  endtask

  task automatic push_exp();
    q.push_back({m_mode, m_param, m_fr, m_fc, m_pm, m_dirty});
  endtask

  task automatic do_press(input logic [1:0] k);
    @(negedge vga_clk);
    KEY = ~k;
    model_press(k);
    repeat (10) @(negedge vga_clk);
    KEY = 2'b11;
    repeat (10) @(negedge vga_clk);
  endtask

  task automatic do_glitch();
    int n;
    n = $urandom_range(1, 3);
    @(negedge vga_clk);
    KEY[0] = 0;
    repeat (n) @(negedge vga_clk);
    KEY[0] = 1;
    repeat (8) @(negedge vga_clk);
    chk("glitch_pending_mode", LEDR[7:5], m_pm);
    chk("glitch_dirty", LEDR[4], m_dirty);
  endtask

  task automatic do_frame(input logic [9:0] sw, input int hold);
    @(negedge vga_clk);
    SW = sw;
    v_sync = 1;
    model_commit(sw);
    push_exp();
    repeat (hold) @(negedge vga_clk);
    v_sync = 0;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic do_simul();
    @(negedge vga_clk);
    KEY[0] = 0;
    repeat (6) @(negedge vga_clk);
    SW = 10'($urandom);
    v_sync = 1;
    model_commit(SW);
    model_press(2'b01);
    push_exp();
    repeat (4) @(negedge vga_clk);
    v_sync = 0;
    KEY = 2'b11;
    repeat (10) @(negedge vga_clk);
    chk("simul_dirty", LEDR[4], 1);
    chk("simul_mode_old", mode, m_mode);
    chk("simul_pending_new", LEDR[7:5], m_pm);
  endtask

  // Monitor: every frame_count step is a commit and is matched against the scoreboard
  initial begin
    logic [7:0] last;
    exp_t e;
    last = 0;
    forever begin
      @(negedge vga_clk);
      if (!rst_n) last = 0;
      else if (frame_count !== last) begin
        last = frame_count;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_commit: frame_count %0h with no expected commit", frame_count);
        end else begin
          e = q.pop_front();
          chk("commit_mode", mode, e.mode);
          chk("commit_param", param, e.param);
          chk("commit_freeze", freeze, e.fr);
          chk("commit_frame_count", frame_count, e.fc);
          @(negedge vga_clk);
          chk("ledr", LEDR, {e.fc[1:0], e.pm, e.dirty, e.fr, e.mode});
          chk("hex0", HEX0, seg(e.param[3:0]));
          chk("hex1", HEX1, seg(e.param[7:4]));
          chk("hex2", HEX2, seg({2'b00, e.param[9:8]}));
          chk("hex3", HEX3, 8'hFF);
          chk("hex4", HEX4, seg({1'b0, e.pm}));
          chk("hex5", HEX5, seg({1'b0, e.mode}));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge vga_clk);
    chk("rst_mode", mode, 0);
    chk("rst_param", param, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_ledr", LEDR, 0);
    chk("rst_hex0", HEX0, 8'hC0);
    chk("rst_hex3", HEX3, 8'hFF);
    chk("rst_hex5", HEX5, 8'hC0);
    rst_n = 1;
    repeat (3) @(negedge vga_clk);
    // mode commit
    do_press(2'b01);
    chk("pre_pending_mode", LEDR[7:5], 1);
    chk("pre_dirty", LEDR[4], 1);
    chk("pre_mode", mode, 0);
    do_frame(10'h2A5, 2);
    // debounce and wrap
    do_glitch();
    repeat (5) do_press(2'b01);
    do_frame(10'($urandom), 1);
    // freeze
    do_press(2'b10);
    do_frame(10'($urandom), 1);
    do_press(2'b01);
    do_frame(10'h3FF, 1);
    do_press(2'b10);
    do_frame(10'($urandom), 1);
    // simultaneous press and commit, then apply at next frame
    do_simul();
    do_frame(10'($urandom), 1);
    // long v_sync high
    do_frame(10'($urandom), 100);
    // mid-run async reset
    repeat (4) @(negedge vga_clk);
    @(posedge vga_clk);
    #3 rst_n = 0;
    #1;
    chk("mrst_mode", mode, 0);
    chk("mrst_param", param, 0);
    chk("mrst_freeze", freeze, 0);
    chk("mrst_fc", frame_count, 0);
    chk("mrst_ledr", LEDR, 0);
    chk("mrst_hex0", HEX0, 8'hC0);
    chk("mrst_hex3", HEX3, 8'hFF);
    model_reset();
    repeat (4) begin
      @(negedge vga_clk);
      v_sync = ~v_sync;
    end
    v_sync = 1;
    @(negedge vga_clk);
    rst_n = 1;
    repeat (6) @(negedge vga_clk);
    chk("no_commit_vsync_high", frame_count, 0);
    v_sync = 0;
    repeat (2) @(negedge vga_clk);
    do_frame(10'($urandom), 1);
    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: do_press(2'b01);
        1: do_press(2'b10);
        2: do_press(2'b11);
        3: do_glitch();
        default: do_frame(10'($urandom), $urandom_range(1, 4));
      endcase
    end
    // frame counter wrap
    for (int i = 0; i < 256; i++) do_frame(10'($urandom), 1);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge vga_clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge vga_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
